// File: rtl/ex_stage_if.sv
// EX-stage bundle: ID/EX operands and controls in, EX/MEM register and branch redirect out.
// The pipeline side drives through 'master'; the execute stage itself uses 'slave'.
interface ex_stage_if #(
  parameter int REG_NO = 8,
  parameter int XLEN   = 32
);
  localparam int AW = $clog2(REG_NO);

  logic            stall_ex;
  logic            flush_ex;
  logic            id_valid;
  logic [XLEN-1:0] pc_EX;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm_EX;
  logic [3:0]      alu_op;
  logic            alu_src_a;
  logic            alu_src_b;
  logic            is_branch;
  logic [2:0]      br_funct3;
  logic [AW-1:0]   dest_add_EX;
  logic            R_write_EX;
  logic            mem_write_EX;
  logic            mem_read_EX;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [XLEN-1:0] wb_data_WB;

  logic [XLEN-1:0] alu_result_ME;
  logic [XLEN-1:0] store_data_ME;
  logic [AW-1:0]   dest_add_ME;
  logic            R_write_ME;
  logic            mem_write_ME;
  logic            mem_read_ME;
  logic            valid_ME;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;

  modport master (
    output stall_ex, flush_ex, id_valid, pc_EX, rs1_data, rs2_data, imm_EX,
           alu_op, alu_src_a, alu_src_b, is_branch, br_funct3, dest_add_EX,
           R_write_EX, mem_write_EX, mem_read_EX, fwd_a, fwd_b, wb_data_WB,
    input  alu_result_ME, store_data_ME, dest_add_ME, R_write_ME, mem_write_ME,
           mem_read_ME, valid_ME, branch_taken, branch_target
  );

  modport slave (
    input  stall_ex, flush_ex, id_valid, pc_EX, rs1_data, rs2_data, imm_EX,
           alu_op, alu_src_a, alu_src_b, is_branch, br_funct3, dest_add_EX,
           R_write_EX, mem_write_EX, mem_read_EX, fwd_a, fwd_b, wb_data_WB,
    output alu_result_ME, store_data_ME, dest_add_ME, R_write_ME, mem_write_ME,
           mem_read_ME, valid_ME, branch_taken, branch_target
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Branch redirect is combinational; everything else appears one cycle later on the ME side.
module ex_stage #(
  parameter int REG_NO = 8,
  parameter int XLEN   = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  ex_stage_if.slave bus
);
  localparam int AW = $clog2(REG_NO);

  logic [XLEN-1:0] alu_result_reg;
  logic [XLEN-1:0] store_data_reg;
  logic [AW-1:0]   dest_add_reg;
  logic            r_write_reg;
  logic            mem_write_reg;
  logic            mem_read_reg;
  logic            valid_reg;

  // Per-operand forwarding: index 0 is operand A (rs1), index 1 is operand B (rs2).
  logic [1:0][XLEN-1:0] rf_val;
  logic [1:0][1:0]      fwd_sel;
  logic [1:0][XLEN-1:0] fwd_val;

  assign rf_val[0]  = bus.rs1_data;
  assign rf_val[1]  = bus.rs2_data;
  assign fwd_sel[0] = bus.fwd_a;
  assign fwd_sel[1] = bus.fwd_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      // ME forwarding reads the register output, so a stalled stage forwards its held result.
      assign fwd_val[gi] = (fwd_sel[gi] == 2'd0) ? rf_val[gi]     :
                           (fwd_sel[gi] == 2'd1) ? bus.wb_data_WB :
                           (fwd_sel[gi] == 2'd2) ? alu_result_reg :
                                                   '0;
    end
  endgenerate

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic            alu_lt_s;
  logic            alu_lt_u;
  logic [XLEN-1:0] alu_res;

  assign op_a     = bus.alu_src_a ? bus.pc_EX  : fwd_val[0];
  assign op_b     = bus.alu_src_b ? bus.imm_EX : fwd_val[1];
  assign shamt    = op_b[4:0];
  assign alu_lt_s = $signed(op_a) < $signed(op_b);
  assign alu_lt_u = op_a < op_b;

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, alu_lt_s};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, alu_lt_u};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Branches always compare the forwarded register values, independent of ALU source muxes.
  logic br_eq;
  logic br_lt_s;
  logic br_lt_u;
  logic br_cond;

  assign br_eq   = fwd_val[0] == fwd_val[1];
  assign br_lt_s = $signed(fwd_val[0]) < $signed(fwd_val[1]);
  assign br_lt_u = fwd_val[0] < fwd_val[1];

  always_comb begin
    br_cond = 1'b0;
    case (bus.br_funct3)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = ~br_eq;
      3'b100:  br_cond = br_lt_s;
      3'b101:  br_cond = ~br_lt_s;
      3'b110:  br_cond = br_lt_u;
      3'b111:  br_cond = ~br_lt_u;
      default: br_cond = 1'b0;
    endcase
  end

  assign bus.branch_taken  = bus.id_valid & bus.is_branch & br_cond & ~bus.stall_ex;
  assign bus.branch_target = bus.pc_EX + bus.imm_EX;

  // Writes to x0 are dropped here so downstream forwarding never sees them.
  logic r_write_next;
  assign r_write_next = bus.R_write_EX & bus.id_valid & (bus.dest_add_EX != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_ex) begin
      alu_result_reg <= '0;
      store_data_reg <= '0;
      dest_add_reg   <= '0;
      r_write_reg    <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      valid_reg      <= 1'b0;
    end else if (!bus.stall_ex) begin
      alu_result_reg <= alu_res;
      store_data_reg <= fwd_val[1];
      dest_add_reg   <= bus.dest_add_EX;
      r_write_reg    <= r_write_next;
      mem_write_reg  <= bus.mem_write_EX & bus.id_valid;
      mem_read_reg   <= bus.mem_read_EX & bus.id_valid;
      valid_reg      <= bus.id_valid;
    end
  end

  assign bus.alu_result_ME = alu_result_reg;
  assign bus.store_data_ME = store_data_reg;
  assign bus.dest_add_ME   = dest_add_reg;
  assign bus.R_write_ME    = r_write_reg;
  assign bus.mem_write_ME  = mem_write_reg;
  assign bus.mem_read_ME   = mem_read_reg;
  assign bus.valid_ME      = valid_reg;
endmodule
